pixel_fifo_reader: RTL and testbench

Read-side controller for the 24-bit pixel line FIFO in the HDMI contrast-adjust path. The FIFO has no flags, so this block taps the writer's write strobe to track FIFO occupancy. It issues `rd_en` only when data is present and absorbs the FIFO's one-cycle read latency in a 3-entry output queue. Pixels leave on a valid/ready stream toward the contrast-adjust pipeline, at up to one per cycle under backpressure.

---
 rtl/pixel_fifo_reader_if.sv | 38 +++
 rtl/pixel_fifo_reader.sv | 111 +++++++++++
 tb/tb_pixel_fifo_reader.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_fifo_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fifo_reader_if
// Description : Bundles the FIFO read-side strobes and the outgoing pixel
//               valid/ready stream of the pixel FIFO reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_fifo_reader_if #(
    parameter int DATA_W = 24
) ();
    logic              fifo_wr_en;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    // Reader side
    modport master (
        input  fifo_wr_en,
        output fifo_rd_en,
        input  fifo_rd_data,
        output m_valid,
        output m_data,
        input  m_ready
    );

    // FIFO / downstream side
    modport slave (
        output fifo_wr_en,
        input  fifo_rd_en,
        output fifo_rd_data,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/pixel_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fifo_reader
// Description : Read controller for a flagless pixel line FIFO. Tracks FIFO
//               occupancy from the writer's strobe, issues reads only when
//               data is present and hides the one-cycle read latency behind
//               a 3-entry output queue feeding a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo_reader #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 200,
    parameter int CNT_W  = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    pixel_fifo_reader_if.master   bus,
    output logic [CNT_W-1:0]      level,
    output logic                  overflow,
    input  wire logic             clr_err
);

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [CNT_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              in_flight_q, in_flight_d;
    logic [1:0]        q_count_q, q_count_d;
    logic [DATA_W-1:0] mem_q [3];
    logic [DATA_W-1:0] mem_d [3];

    logic              w_rd_en;
    logic              w_push;
    logic              w_pop;
    logic              w_ov_evt;
    logic [1:0]        w_wr_idx;

    // Read issue decoded from registers only: data in the FIFO and room for
    // it once everything already in flight has landed in the queue.
    assign w_rd_en = (level_q != '0) &&
                     (({1'b0, q_count_q} + {2'b00, in_flight_q}) < 3'd3);

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = (q_count_q != 2'd0);
    assign bus.m_data     = mem_q[0];
    assign level          = level_q;
    assign overflow       = overflow_q;

    // Occupancy tracking and sticky overflow (set has priority over clear)
    always_comb begin
        level_d  = level_q;
        w_ov_evt = 1'b0;
        if (bus.fifo_wr_en && !w_rd_en) begin
            if (level_q == C_DEPTH) begin
                w_ov_evt = 1'b1;
            end else begin
                level_d = level_q + 1'b1;
            end
        end else if (!bus.fifo_wr_en && w_rd_en) begin
            level_d = level_q - 1'b1;
        end

        if (w_ov_evt) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Output queue: head at index 0, shift on pop, append at the tail on push
    always_comb begin
        w_push      = in_flight_q;
        w_pop       = (q_count_q != 2'd0) && bus.m_ready;
        in_flight_d = w_rd_en;
        mem_d       = mem_q;
        if (w_pop) begin
            mem_d[0] = mem_q[1];
            mem_d[1] = mem_q[2];
        end
        w_wr_idx = q_count_q - {1'b0, w_pop};
        if (w_push) begin
            mem_d[w_wr_idx] = bus.fifo_rd_data;
        end
        q_count_d = q_count_q + {1'b0, w_push} - {1'b0, w_pop};
    end

    // State registers; reset discards queued and in-flight pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q     <= '0;
            overflow_q  <= 1'b0;
            in_flight_q <= 1'b0;
            q_count_q   <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            in_flight_q <= in_flight_d;
            q_count_q   <= q_count_d;
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_fifo_reader
// Description : Scoreboard bench for pixel_fifo_reader with a behavioural
//               200-entry flagless FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_fifo_reader;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 200;
    localparam int CNT_W  = 8;

    logic             clk;
    logic             rst_n;
    logic             clr_err;
    logic [CNT_W-1:0] level;
    logic             overflow;
    logic [DATA_W-1:0] wdata;

    int n_checks;
    int n_fail;
    int rd_cnt;
    int cur_run;
    int max_run;
    bit sb_en;
    logic [DATA_W-1:0] sb_q [$];

    logic [DATA_W-1:0] fifo_mem [DEPTH];
    int                fifo_wp;
    int                fifo_rp;

    pixel_fifo_reader_if #(.DATA_W(DATA_W)) bus ();

    pixel_fifo_reader #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .level    (level),
        .overflow (overflow),
        .clr_err  (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural flagless FIFO: registered read data, writes always land
    always @(posedge clk) begin
        if (!rst_n) begin
            fifo_wp <= 0;
            fifo_rp <= 0;
        end else begin
            if (bus.fifo_rd_en) begin
                bus.fifo_rd_data <= fifo_mem[fifo_rp];
                fifo_rp <= (fifo_rp == DEPTH - 1) ? 0 : fifo_rp + 1;
            end
            if (bus.fifo_wr_en) begin
                fifo_mem[fifo_wp] <= wdata;
                fifo_wp <= (fifo_wp == DEPTH - 1) ? 0 : fifo_wp + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output pixel is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n && sb_en && bus.m_valid && bus.m_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pixel", 32'(bus.m_data), 32'hFFFF_FFFF);
            end else begin
                chk("pixel_order", 32'(bus.m_data), 32'(sb_q.pop_front()));
            end
        end
    end

    // One clock, inputs changed 1 time unit after the edge; tracks rd_en runs
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.fifo_rd_en) begin
            rd_cnt++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            cur_run = 0;
        end
    endtask

    task automatic write_px(input logic [DATA_W-1:0] v);
        bus.fifo_wr_en = 1'b1;
        wdata          = v;
        if (sb_en) sb_q.push_back(v);
        step();
        bus.fifo_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        sb_q.delete();
        rst_n = 1'b1;
        step();
    endtask

    task automatic drain(input string name, input bit rnd, input int budget);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || bus.m_valid) && k < budget) begin
            bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            k++;
        end
        bus.m_ready = 1'b1;
        chk(name, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0; rd_cnt = 0; cur_run = 0; max_run = 0;
        sb_en = 1'b1;
        rst_n = 1'b0; clr_err = 1'b0; wdata = '0;
        bus.fifo_wr_en = 1'b0; bus.m_ready = 1'b1;
        #13;
        chk("reset_rd_en", 32'(bus.fifo_rd_en), 0);
        chk("reset_m_valid", 32'(bus.m_valid), 0);
        chk("reset_m_data", 32'(bus.m_data), 0);
        step();
        rst_n = 1'b1;

        // Idle after reset: nothing moves for 20 cycles
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_rd_en", 32'(bus.fifo_rd_en), 0);
            chk("idle_m_valid", 32'(bus.m_valid), 0);
            chk("idle_overflow", 32'(overflow), 0);
            chk("idle_level", 32'(level), 0);
        end

        // Single pixel latency
        write_px(24'h123456);
        chk("single_rd_en_n1", 32'(bus.fifo_rd_en), 1);
        chk("single_level_n1", 32'(level), 1);
        chk("single_valid_n1", 32'(bus.m_valid), 0);
        step();
        chk("single_rd_en_n2", 32'(bus.fifo_rd_en), 0);
        chk("single_valid_n2", 32'(bus.m_valid), 0);
        chk("single_level_n2", 32'(level), 0);
        step();
        chk("single_valid_n3", 32'(bus.m_valid), 1);
        chk("single_data_n3", 32'(bus.m_data), 32'h123456);
        step();
        chk("single_valid_n4", 32'(bus.m_valid), 0);
        chk("single_sb_empty", 32'(sb_q.size()), 0);

        // Streaming 0..199 at full rate
        rd_cnt = 0; cur_run = 0; max_run = 0;
        bus.fifo_wr_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            wdata = DATA_W'(i);
            sb_q.push_back(DATA_W'(i));
            step();
            chk("stream_level_le2", 32'(level <= 2), 1);
        end
        bus.fifo_wr_en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("stream_rd_count", 32'(rd_cnt), 200);
        chk("stream_rd_contiguous", 32'(max_run), 200);
        chk("stream_level_end", 32'(level), 0);
        drain("stream_drained", 1'b0, 20);

        // Backpressure: 10 writes with downstream stalled
        bus.m_ready = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) write_px(24'hB00000 + DATA_W'(i));
        for (int i = 0; i < 3; i++) step();
        chk("bp_rd_count", 32'(rd_cnt), 3);
        chk("bp_level", 32'(level), 7);
        chk("bp_q_count", 32'(dut.q_count_q), 3);
        chk("bp_m_valid", 32'(bus.m_valid), 1);
        chk("bp_m_data_frozen", 32'(bus.m_data), 32'hB00000);
        drain("bp_drained", 1'b1, 500);
        chk("bp_level_end", 32'(level), 0);

        // Fill to DEPTH with downstream stalled, then overflow cases
        do_reset();
        sb_en = 1'b0;
        bus.m_ready = 1'b0;
        bus.fifo_wr_en = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            wdata = 24'hC00000 + DATA_W'(i);
            step();
        end
        bus.fifo_wr_en = 1'b0;
        step();
        chk("full_level", 32'(level), 200);
        chk("full_no_overflow", 32'(overflow), 0);
        chk("full_rd_en_off", 32'(bus.fifo_rd_en), 0);
        write_px(24'hDEAD01);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_level_held", 32'(level), 200);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        chk("full_rd_en_on", 32'(bus.fifo_rd_en), 1);
        write_px(24'hDEAD02);
        chk("wr_rd_full_no_ovf", 32'(overflow), 0);
        chk("wr_rd_full_level", 32'(level), 200);
        chk("full_rd_en_off2", 32'(bus.fifo_rd_en), 0);
        clr_err = 1'b1;
        write_px(24'hDEAD03);
        clr_err = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 1);
        chk("ovf_level_held2", 32'(level), 200);

        // Async reset with one pixel queued and one in flight
        do_reset();
        sb_en = 1'b1;
        bus.m_ready = 1'b0;
        write_px(24'hE00001);
        write_px(24'hE00002);
        step();
        chk("pre_rst_in_flight", 32'(dut.in_flight_q), 1);
        chk("pre_rst_q_count", 32'(dut.q_count_q), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 32'(bus.m_valid), 0);
        chk("arst_m_data", 32'(bus.m_data), 0);
        chk("arst_rd_en", 32'(bus.fifo_rd_en), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_overflow", 32'(overflow), 0);
        sb_q.delete();
        step();
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_m_valid", 32'(bus.m_valid), 0);
        end
        write_px(24'hF00F00);
        drain("post_rst_drained", 1'b0, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
